// File: rtl/pacman_pkg.sv
`default_nettype none
// ============================================================================
// pacman_pkg : shared map geometry, read-slot indices and tile encoding
// Rev 1.0
// ============================================================================
package pacman_pkg;

    localparam int MAP_BITS  = 5;
    localparam int NUM_SLOTS = 5;

    typedef logic [2:0] slot_t;

    localparam slot_t SLOT_C = 3'd0;
    localparam slot_t SLOT_U = 3'd1;
    localparam slot_t SLOT_D = 3'd2;
    localparam slot_t SLOT_L = 3'd3;
    localparam slot_t SLOT_R = 3'd4;

    localparam int TILE_TYPE_LSB = 0;
    localparam int TILE_TYPE_W   = 2;

    typedef enum logic [1:0] {
        TILE_EMPTY = 2'd0,
        TILE_WALL  = 2'd1,
        TILE_DOOR  = 2'd2,
        TILE_GATE  = 2'd3
    } tile_type_e;

    // Anything other than an empty tile blocks movement.
    function automatic logic tile_is_wall(input logic [7:0] tile);
        tile_type_e t;
        t = tile_type_e'(tile[TILE_TYPE_LSB +: TILE_TYPE_W]);
        return t != TILE_EMPTY;
    endfunction

endpackage
`default_nettype wire

// File: rtl/neighbor_addr_gen.sv
`default_nettype none
// ============================================================================
// neighbor_addr_gen : tile RAM address {row, col} of the centre or one of its
// four neighbours, wrapping around the map edges. Rev 1.0
// ============================================================================
module neighbor_addr_gen
    import pacman_pkg::*;
#(
    parameter int MAP_BITS = pacman_pkg::MAP_BITS
) (
    input  logic [MAP_BITS-1:0]   x_i,
    input  logic [MAP_BITS-1:0]   y_i,
    input  slot_t                 slot_i,
    output logic [2*MAP_BITS-1:0] addr_o
);

    localparam logic [MAP_BITS-1:0] C_ONE = 1;

    logic [MAP_BITS-1:0] row;
    logic [MAP_BITS-1:0] col;

    // Plain MAP_BITS-wide add/sub gives the torus wrap for free.
    always_comb begin
        row = y_i;
        col = x_i;
        case (slot_i)
            SLOT_U:  row = y_i - C_ONE;
            SLOT_D:  row = y_i + C_ONE;
            SLOT_L:  col = x_i - C_ONE;
            SLOT_R:  col = x_i + C_ONE;
            default: ;
        endcase
    end

    assign addr_o = {row, col};

endmodule
`default_nettype wire

// File: rtl/cell_neighbor_reader.sv
`default_nettype none
// ============================================================================
// cell_neighbor_reader : fetches the tile bytes of a cell and its four
// neighbours through a shared, arbitrated tile RAM port. Rev 1.0
// ============================================================================
module cell_neighbor_reader
    import pacman_pkg::*;
#(
    parameter int MAP_BITS = pacman_pkg::MAP_BITS
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic [MAP_BITS-1:0]   req_x,
    input  logic [MAP_BITS-1:0]   req_y,
    input  logic                  ram_grant,
    output logic                  ram_rd,
    output logic [2*MAP_BITS-1:0] ram_addr,
    input  logic [7:0]            ram_dout,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [7:0]            rsp_c,
    output logic [7:0]            rsp_u,
    output logic [7:0]            rsp_d,
    output logic [7:0]            rsp_l,
    output logic [7:0]            rsp_r,
    output logic [3:0]            rsp_walls
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_ISSUE = 2'd1;
    localparam logic [1:0] S_DRAIN = 2'd2;
    localparam logic [1:0] S_RESP  = 2'd3;

    logic [1:0]            state_q, state_d;
    logic [MAP_BITS-1:0]   x_q, y_q;
    slot_t                 idx_q, slot_q;
    logic                  issued_q;
    logic                  live_q;
    logic [7:0]            tile_q [NUM_SLOTS];
    logic [2*MAP_BITS-1:0] nb_addr;
    logic                  accept;

    neighbor_addr_gen #(
        .MAP_BITS (MAP_BITS)
    ) u_addr_gen (
        .x_i    (x_q),
        .y_i    (y_q),
        .slot_i (idx_q),
        .addr_o (nb_addr)
    );

    // live_q keeps req_ready low until the first edge after reset release.
    assign req_ready = (state_q == S_IDLE) && live_q;
    assign accept    = req_valid && req_ready;
    assign ram_rd    = (state_q == S_ISSUE);
    assign ram_addr  = ram_rd ? nb_addr : '0;
    assign rsp_valid = (state_q == S_RESP);

    assign rsp_c = tile_q[SLOT_C];
    assign rsp_u = tile_q[SLOT_U];
    assign rsp_d = tile_q[SLOT_D];
    assign rsp_l = tile_q[SLOT_L];
    assign rsp_r = tile_q[SLOT_R];

    assign rsp_walls = {tile_is_wall(tile_q[SLOT_R]), tile_is_wall(tile_q[SLOT_L]),
                        tile_is_wall(tile_q[SLOT_D]), tile_is_wall(tile_q[SLOT_U])};

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (accept) state_d = S_ISSUE;
            S_ISSUE: if (ram_grant && idx_q == SLOT_R) state_d = S_DRAIN;
            S_DRAIN: if (issued_q && slot_q == SLOT_R) state_d = S_RESP;
            S_RESP:  if (rsp_ready) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= S_IDLE;
            x_q      <= '0;
            y_q      <= '0;
            idx_q    <= '0;
            slot_q   <= '0;
            issued_q <= 1'b0;
            live_q   <= 1'b0;
            for (int i = 0; i < NUM_SLOTS; i++) tile_q[i] <= '0;
        end else begin
            state_q  <= state_d;
            live_q   <= 1'b1;
            // Data returns one cycle after the grant, so remember which slot it belongs to.
            issued_q <= (state_q == S_ISSUE) && ram_grant;
            slot_q   <= idx_q;
            if (accept) begin
                x_q   <= req_x;
                y_q   <= req_y;
                idx_q <= '0;
            end else if (state_q == S_ISSUE && ram_grant) begin
                idx_q <= (idx_q == SLOT_R) ? '0 : idx_q + 3'd1;
            end
            if (issued_q && slot_q <= SLOT_R) tile_q[slot_q] <= ram_dout;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_cell_neighbor_reader.sv
`default_nettype none
// ============================================================================
// tb_cell_neighbor_reader : directed queries against a tile RAM model, with
// scoreboarded read addresses and responses. Rev 1.0
// ============================================================================
module tb_cell_neighbor_reader;

    typedef struct packed {
        logic [7:0] c, u, d, l, r;
        logic [3:0] w;
    } rsp_t;

    logic       clk;
    logic       reset;
    logic       req_valid;
    logic       req_ready;
    logic [4:0] req_x, req_y;
    logic       ram_grant;
    logic       ram_rd;
    logic [9:0] ram_addr;
    logic [7:0] ram_dout;
    logic       rsp_valid;
    logic       rsp_ready;
    logic [7:0] rsp_c, rsp_u, rsp_d, rsp_l, rsp_r;
    logic [3:0] rsp_walls;

    int n_checks = 0;
    int n_pass   = 0;

    rsp_t       exp_rsp_q  [$];
    logic [9:0] exp_addr_q [$];
    logic [7:0] mem [1024];

    cell_neighbor_reader dut (
        .clk       (clk),
        .reset     (reset),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_x     (req_x),
        .req_y     (req_y),
        .ram_grant (ram_grant),
        .ram_rd    (ram_rd),
        .ram_addr  (ram_addr),
        .ram_dout  (ram_dout),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_c     (rsp_c),
        .rsp_u     (rsp_u),
        .rsp_d     (rsp_d),
        .rsp_l     (rsp_l),
        .rsp_r     (rsp_r),
        .rsp_walls (rsp_walls)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Tile RAM: one-cycle read latency; garbage on ungranted cycles.
    always @(posedge clk) begin
        if (ram_rd && ram_grant) ram_dout <= mem[ram_addr];
        else                     ram_dout <= 8'($urandom);
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    // Address scoreboard: every granted read must match the next expected address.
    always @(negedge clk) begin
        if (reset && ram_rd && ram_grant) begin
            if (exp_addr_q.size() == 0) check("unexpected_read", {1'b1, ram_addr}, 11'h0);
            else check("ram_addr", ram_addr, exp_addr_q.pop_front());
        end
    end

    // Response scoreboard: compared on each response handshake.
    always @(negedge clk) begin
        if (reset && rsp_valid && rsp_ready) begin
            if (exp_rsp_q.size() == 0) check("unexpected_rsp", 1, 0);
            else check("rsp", {rsp_c, rsp_u, rsp_d, rsp_l, rsp_r, rsp_walls}, exp_rsp_q.pop_front());
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic check_all_zero(input string name);
        check(name, {req_ready, rsp_valid, ram_rd, ram_addr, rsp_c, rsp_u, rsp_d,
                     rsp_l, rsp_r, rsp_walls}, 57'h0);
    endtask

    task automatic run_query(input logic [4:0] x, input logic [4:0] y, input rsp_t exp,
                             input logic [49:0] addrs, input int stall, input int hold,
                             input int exp_lat);
        int guard;
        int lat;
        guard = 0;
        while (!req_ready && guard < 20) begin
            @(posedge clk); #1;
            guard++;
        end
        check("req_ready_idle", req_ready, 1);
        req_x     = x;
        req_y     = y;
        req_valid = 1'b1;
        rsp_ready = (hold == 0);
        for (int i = 4; i >= 0; i--) exp_addr_q.push_back(addrs[i*10 +: 10]);
        exp_rsp_q.push_back(exp);
        @(posedge clk); #1;
        req_valid = 1'b0;
        lat = 0;
        for (int k = 1; k <= 40; k++) begin
            @(posedge clk); #1;
            if (stall != 0) begin
                if (k >= 2 && k <= 4) check("stall_addr_frozen", {ram_rd, ram_addr}, {1'b1, addrs[39:30]});
                if (k == 1) ram_grant = 1'b0;
                if (k == 4) ram_grant = 1'b1;
            end
            if (rsp_valid) begin
                lat = k;
                break;
            end
        end
        check("rsp_latency", lat, exp_lat);
        for (int h = 0; h < hold; h++) begin
            @(posedge clk); #1;
            check("rsp_hold", {rsp_c, rsp_u, rsp_d, rsp_l, rsp_r, rsp_walls, rsp_valid, req_ready},
                  {exp, 1'b1, 1'b0});
        end
        if (hold > 0) begin
            rsp_ready = 1'b1;
            req_valid = 1'b1;  // must be ignored on the handshake edge
        end
        @(posedge clk); #1;
        check("post_handshake", {rsp_valid, req_ready, ram_rd}, 3'b010);
        req_valid = 1'b0;
        rsp_ready = 1'b0;
    endtask

    initial begin
        for (int i = 0; i < 1024; i++) mem[i] = i[7:0];
        reset     = 1'b0;
        req_valid = 1'b0;
        req_x     = '0;
        req_y     = '0;
        ram_grant = 1'b1;
        rsp_ready = 1'b0;

        repeat (2) @(posedge clk);
        #1;
        check_all_zero("reset_outputs");
        reset = 1'b1;
        #1;
        check("ready_before_first_edge", req_ready, 0);
        @(posedge clk); #1;
        check("ready_after_reset", req_ready, 1);

        // Plain query, data = low byte of address.
        run_query(5'd10, 5'd7, {8'hEA, 8'hCA, 8'h0A, 8'hE9, 8'hEB, 4'b1111},
                  {10'h0EA, 10'h0CA, 10'h10A, 10'h0E9, 10'h0EB}, 0, 0, 6);

        // Wrap: left of column 0 and below row 31.
        run_query(5'd0, 5'd31, {8'hE0, 8'hC0, 8'h00, 8'hFF, 8'hE1, 4'b1100},
                  {10'h3E0, 10'h3C0, 10'h000, 10'h3FF, 10'h3E1}, 0, 0, 6);

        // Grant withheld for three cycles.
        run_query(5'd10, 5'd7, {8'hEA, 8'hCA, 8'h0A, 8'hE9, 8'hEB, 4'b1111},
                  {10'h0EA, 10'h0CA, 10'h10A, 10'h0E9, 10'h0EB}, 1, 0, 9);

        // Consumer back-pressure for five cycles; wrap up and right.
        run_query(5'd31, 5'd0, {8'h1F, 8'hFF, 8'h3F, 8'h1E, 8'h00, 4'b0111},
                  {10'h01F, 10'h3FF, 10'h03F, 10'h01E, 10'h000}, 0, 5, 6);

        // Wall flags: U (0x01) and L (0x06) are non-empty, giving {r,l,d,u} = 0101.
        mem[10'h0A5] = 8'h00;
        mem[10'h085] = 8'h01;
        mem[10'h0C5] = 8'h00;
        mem[10'h0A4] = 8'h06;
        mem[10'h0A6] = 8'h08;
        run_query(5'd5, 5'd5, {8'h00, 8'h01, 8'h00, 8'h06, 8'h08, 4'b0101},
                  {10'h0A5, 10'h085, 10'h0C5, 10'h0A4, 10'h0A6}, 0, 0, 6);

        // Prime response registers with nonzero data, then reset mid-ISSUE.
        run_query(5'd0, 5'd31, {8'hE0, 8'hC0, 8'h00, 8'hFF, 8'hE1, 4'b1100},
                  {10'h3E0, 10'h3C0, 10'h000, 10'h3FF, 10'h3E1}, 0, 0, 6);
        req_x     = 5'd3;
        req_y     = 5'd2;
        req_valid = 1'b1;
        exp_addr_q.push_back(10'h043);
        exp_addr_q.push_back(10'h023);
        @(posedge clk); #1;
        req_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("issue_index2_addr", {ram_rd, ram_addr}, {1'b1, 10'h063});
        reset = 1'b0;
        #1;
        check_all_zero("midquery_reset_outputs");
        exp_addr_q.delete();
        exp_rsp_q.delete();
        @(posedge clk); #1;
        check_all_zero("reset_held_outputs");
        reset = 1'b1;
        @(posedge clk); #1;
        check("ready_after_midquery_reset", req_ready, 1);

        run_query(5'd10, 5'd7, {8'hEA, 8'hCA, 8'h0A, 8'hE9, 8'hEB, 4'b1111},
                  {10'h0EA, 10'h0CA, 10'h10A, 10'h0E9, 10'h0EB}, 0, 0, 6);

        repeat (3) @(posedge clk);
        #1;
        check("scoreboards_drained", {exp_rsp_q.size() == 0, exp_addr_q.size() == 0}, 2'b11);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
